// File: rtl/axrm_seq_mul.sv
// Sequential approximate multiplier: one half-width quadrant sub-product per clock,
// summed into a 2*WIDTH accumulator, with exact/truncate/skip-LL modes per transaction.
module axrm_seq_mul #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TRUNC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic [1:0]           mode_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 busy_o
);

  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] KEEP_MASK = {WIDTH{1'b1}} << TRUNC;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  state_e          state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic            trunc_q;
  logic [1:0]      step_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   result_q;
  logic            in_ready_q, out_valid_q, busy_q;

  logic [H-1:0]     op_a, op_b;
  logic [WIDTH-1:0] sub_full, sub_prod;
  logic [PW-1:0]    term, acc_sum;

  // Step encodes the quadrant: bit 1 selects the high half of a, bit 0 the high half of b.
  always_comb begin
    op_a     = step_q[1] ? a_q[WIDTH-1:H] : a_q[H-1:0];
    op_b     = step_q[0] ? b_q[WIDTH-1:H] : b_q[H-1:0];
    sub_full = WIDTH'(op_a) * WIDTH'(op_b);
    sub_prod = trunc_q ? (sub_full & KEEP_MASK) : sub_full;
    term     = '0;
    unique case (step_q)
      2'd0:       term = {{WIDTH{1'b0}}, sub_prod};
      2'd1, 2'd2: term = {{WIDTH{1'b0}}, sub_prod} << H;
      default:    term = {sub_prod, {WIDTH{1'b0}}};
    endcase
    acc_sum = acc_q + term;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      trunc_q     <= 1'b0;
      step_q      <= 2'd0;
      acc_q       <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            a_q        <= a_i;
            b_q        <= b_i;
            trunc_q    <= mode_i[0];
            // Skip-LL modes start directly at the LH quadrant.
            step_q     <= mode_i[1] ? 2'd1 : 2'd0;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= MUL;
          end
        end
        MUL: begin
          acc_q <= acc_sum;
          if (step_q == 2'd3) begin
            result_q    <= acc_sum;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            step_q <= step_q + 2'd1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_axrm_seq_mul.sv
// Self-checking bench for axrm_seq_mul: directed cases on a 16-bit instance, then
// concurrent randomized streams on 16-bit and 32-bit instances against a quadrant model.
module tb_axrm_seq_mul;

  localparam int unsigned TRUNC = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic iv[2], ir[2], ov[2], ordy[2], bz[2];
  logic [1:0]  md[2];
  logic [63:0] av[2], bv[2], rs[2];
  logic [31:0] r16;
  logic [63:0] r32;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  axrm_seq_mul #(.WIDTH(16), .TRUNC(TRUNC)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(iv[0]), .in_ready_o(ir[0]),
    .a_i(av[0][15:0]), .b_i(bv[0][15:0]), .mode_i(md[0]),
    .out_valid_o(ov[0]), .out_ready_i(ordy[0]), .result_o(r16), .busy_o(bz[0])
  );

  axrm_seq_mul #(.WIDTH(32), .TRUNC(TRUNC)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(iv[1]), .in_ready_o(ir[1]),
    .a_i(av[1][31:0]), .b_i(bv[1][31:0]), .mode_i(md[1]),
    .out_valid_o(ov[1]), .out_ready_i(ordy[1]), .result_o(r32), .busy_o(bz[1])
  );

  assign rs[0] = {32'b0, r16};
  assign rs[1] = r32;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sum of the four shifted quadrant products, with LL dropped and/or low bits cleared.
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic [1:0] m, input int w);
    int          h;
    logic [63:0] mask, x, y, p, sum;
    h    = w / 2;
    mask = (64'd1 << h) - 64'd1;
    sum  = 64'd0;
    for (int q = 0; q < 4; q++) begin
      if (q == 0 && m[1]) continue;
      x = (q >= 2) ? ((a >> h) & mask) : (a & mask);
      y = (q % 2 == 1) ? ((b >> h) & mask) : (b & mask);
      p = x * y;
      if (m[0]) p = (p >> TRUNC) << TRUNC;
      if (q == 0)      sum = sum + p;
      else if (q == 3) sum = sum + (p << (2 * h));
      else             sum = sum + (p << h);
    end
    return sum;
  endfunction

  // One transaction on the 16-bit instance, holding out_ready low for 'hold' cycles.
  task automatic run_txn(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] m, input logic [63:0] exp, input int exp_lat,
                         input int hold);
    int lat;
    bit stable;
    @(negedge clk);
    iv[0] = 1'b1; av[0] = 64'(a); bv[0] = 64'(b); md[0] = m;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    check({tag, "_busy"}, 64'(bz[0]), 64'd1);
    lat = 0;
    while (!ov[0] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, rs[0], exp);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (rs[0] !== exp || ov[0] !== 1'b1 || ir[0] !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) check({tag, "_hold"}, 64'(stable), 64'd1);
    @(negedge clk);
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    check({tag, "_ov_after"}, 64'(ov[0]), 64'd0);
    check({tag, "_ir_after"}, 64'(ir[0]), 64'd1);
    check({tag, "_res_kept"}, rs[0], exp);
  endtask

  // Back-to-back random stream with random backpressure, checked in order against the model.
  task automatic stream(input int k, input int w, input int n);
    logic [63:0] q[$];
    logic [63:0] wm;
    wm = (64'd1 << w) - 64'd1;
    fork
      begin
        int c;
        logic [63:0] a, b;
        logic [1:0]  m;
        for (int i = 0; i < n; i++) begin
          @(negedge clk);
          if ($urandom_range(0, 3) == 0) begin
            iv[k] = 1'b0;
            @(negedge clk);
          end
          a = {32'($urandom), 32'($urandom)} & wm;
          b = {32'($urandom), 32'($urandom)} & wm;
          if ($urandom_range(0, 7) == 0) a = wm;
          m = 2'($urandom_range(0, 3));
          iv[k] = 1'b1; av[k] = a; bv[k] = b; md[k] = m;
          c = 0;
          while (!ir[k] && c < 200) begin
            @(negedge clk);
            c++;
          end
          q.push_back(model(a, b, m, w));
          @(posedge clk);
        end
        @(negedge clk);
        iv[k] = 1'b0;
      end
      begin
        int c, got;
        c = 0; got = 0;
        while (got < n && c < 20000) begin
          @(negedge clk);
          c++;
          ordy[k] = 1'($urandom_range(0, 1));
          if (ov[k] && ordy[k]) begin
            if (q.size() == 0) check($sformatf("stream%0d_extra", w), 64'd1, 64'd0);
            else               check($sformatf("stream%0d_res", w), rs[k], q.pop_front());
            got++;
          end
        end
        ordy[k] = 1'b0;
        check($sformatf("stream%0d_count", w), 64'(got), 64'(n));
      end
    join
  endtask

  initial begin
    logic [15:0] ra, rb;
    int lat;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; md[k] = 2'd0; av[k] = '0; bv[k] = '0;
    end
    rst_n = 1'b0;
    #23;
    check("rst_in_ready", 64'(ir[0]), 64'd1);
    check("rst_out_valid", 64'(ov[0]), 64'd0);
    check("rst_busy", 64'(bz[0]), 64'd0);
    check("rst_result", rs[0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn("basic", 16'h1234, 16'h5678, 2'd0, 64'h0626_0060, 4, 0);
    run_txn("ff_m0", 16'hFFFF, 16'hFFFF, 2'd0, 64'hFFFE_0001, 4, 0);
    run_txn("ff_m1", 16'hFFFF, 16'hFFFF, 2'd1, 64'hFFFC_FE00, 4, 0);
    run_txn("ff_m2", 16'hFFFF, 16'hFFFF, 2'd2, 64'hFFFD_0200, 3, 0);
    run_txn("ff_m3", 16'hFFFF, 16'hFFFF, 2'd3, 64'hFFFC_0000, 3, 0);
    run_txn("bp",    16'h00FF, 16'h0101, 2'd0, 64'h0000_FFFF, 4, 10);

    // in_valid stays high with scrambled operands while busy; first operands must win.
    @(negedge clk);
    iv[0] = 1'b1; av[0] = 64'd3; bv[0] = 64'd5; md[0] = 2'd0;
    @(posedge clk); #1;
    lat = 0;
    while (!ov[0] && lat < 20) begin
      av[0] = 64'($urandom); bv[0] = 64'($urandom); md[0] = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      lat++;
    end
    iv[0] = 1'b0;
    check("ignore_lat", 64'(lat), 64'd4);
    check("ignore_res", rs[0], 64'd15);
    @(negedge clk);
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;

    // Reset while the third MUL step is in flight.
    @(negedge clk);
    iv[0] = 1'b1; av[0] = 64'hABCD; bv[0] = 64'h1357; md[0] = 2'd0;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(ov[0]), 64'd0);
    check("midrst_in_ready", 64'(ir[0]), 64'd1);
    check("midrst_busy", 64'(bz[0]), 64'd0);
    check("midrst_result", rs[0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ra = 16'($urandom); rb = 16'($urandom);
    run_txn("after_rst", ra, rb, 2'd1, model(64'(ra), 64'(rb), 2'd1, 16), 4, 2);

    fork
      stream(0, 16, 150);
      stream(1, 32, 150);
    join

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
